inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder_pkg.sv | 42 ++++
 rtl/inst_pack.sv | 61 ++++++
 rtl/inst_encoder.sv | 94 +++++++++
 tb/tb_inst_encoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_pkg.sv
// ============================================================================
//  inst_encoder_pkg
//  Shared ALU operation codes and RV32I opcode/funct constants.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package inst_encoder_pkg;

    // ALU operation codes shared by the ALU control decoder and this encoder.
    // Code 0 and codes 11..15 are not defined.
    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_EQ   = 4'd9;
    localparam logic [3:0] ALU_NE   = 4'd10;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] OPC_B = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

`default_nettype wire

// File: rtl/inst_pack.sv
// ============================================================================
//  inst_pack
//  Combinational packing of an ALU command into an RV32I instruction word.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module inst_pack
    import inst_encoder_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  logic [ALUOP_W-1:0] aluop,
    input  logic               use_imm,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [12:0]        imm,
    output logic [31:0]        word,
    output logic               illegal
);

    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_shift;
    logic       w_branch;

    always_comb begin
        w_f3     = F3_ADD;
        w_f7     = F7_BASE;
        w_shift  = 1'b0;
        w_branch = 1'b0;
        illegal  = 1'b0;
        case (aluop)
            ALU_ADD: w_f3 = F3_ADD;
            ALU_SUB: begin w_f3 = F3_ADD; w_f7 = F7_ALT; illegal = use_imm; end
            ALU_AND: w_f3 = F3_AND;
            ALU_OR:  w_f3 = F3_OR;
            ALU_XOR: w_f3 = F3_XOR;
            ALU_SLL: begin w_f3 = F3_SLL; w_shift = 1'b1; end
            ALU_SRL: begin w_f3 = F3_SR;  w_shift = 1'b1; end
            ALU_SRA: begin w_f3 = F3_SR;  w_shift = 1'b1; w_f7 = F7_ALT; end
            ALU_EQ:  begin w_f3 = F3_BEQ; w_branch = 1'b1; end
            ALU_NE:  begin w_f3 = F3_BNE; w_branch = 1'b1; end
            default: illegal = 1'b1;
        endcase

        // Branches ignore use_imm; shifts keep funct7 above the 5-bit shamt.
        if (w_branch)
            word = {imm[12], imm[10:5], rs2, rs1, w_f3, imm[4:1], imm[11], OPC_B};
        else if (!use_imm)
            word = {w_f7, rs2, rs1, w_f3, rd, OPC_R};
        else if (w_shift)
            word = {w_f7, imm[4:0], rs1, w_f3, rd, OPC_I};
        else
            word = {imm[11:0], rs1, w_f3, rd, OPC_I};
    end

endmodule

`default_nettype wire

// File: rtl/inst_encoder.sv
// ============================================================================
//  inst_encoder
//  Command-to-instruction encoder with ready/valid write port and address counter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int inst_width  = 32,
    parameter int ALUop_width = 4,
    parameter int addr_width  = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ALUop_width-1:0] cmd_aluop,
    input  logic                   cmd_use_imm,
    input  logic [4:0]             cmd_rd,
    input  logic [4:0]             cmd_rs1,
    input  logic [4:0]             cmd_rs2,
    input  logic [12:0]            cmd_imm,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [addr_width-1:0]  wr_addr,
    output logic [inst_width-1:0]  wr_data,
    output logic                   err_illegal,
    output logic [7:0]             illegal_cnt
);

    logic [31:0]           w_word;
    logic                  w_illegal;
    logic                  w_accept;
    logic                  w_drain;
    logic                  r_wr_valid;
    logic [addr_width-1:0] r_wr_addr;
    logic [inst_width-1:0] r_wr_data;
    logic                  r_err;
    logic [7:0]            r_cnt;

    inst_pack #(
        .ALUOP_W (ALUop_width)
    ) u_pack (
        .aluop   (cmd_aluop),
        .use_imm (cmd_use_imm),
        .rd      (cmd_rd),
        .rs1     (cmd_rs1),
        .rs2     (cmd_rs2),
        .imm     (cmd_imm),
        .word    (w_word),
        .illegal (w_illegal)
    );

    assign cmd_ready = !r_wr_valid || wr_ready;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_drain   = r_wr_valid && wr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_err      <= 1'b0;
            r_cnt      <= 8'd0;
        end else begin
            // Address advances on every completed write; wraps by natural overflow.
            if (w_drain)
                r_wr_addr <= r_wr_addr + 1'b1;

            if (w_accept)
                r_wr_valid <= !w_illegal;
            else if (w_drain)
                r_wr_valid <= 1'b0;

            if (w_accept && !w_illegal)
                r_wr_data <= inst_width'(w_word);

            r_err <= w_accept && w_illegal;
            if (w_accept && w_illegal && (r_cnt != 8'hFF))
                r_cnt <= r_cnt + 8'd1;
        end
    end

    assign wr_valid    = r_wr_valid;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign err_illegal = r_err;
    assign illegal_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder.sv
// ============================================================================
//  tb_inst_encoder
//  Directed self-checking bench for inst_encoder (default and 2-bit address).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_inst_encoder;
    import inst_encoder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic        rst, cmd_valid, cmd_ready, cmd_use_imm;
    logic [3:0]  cmd_aluop;
    logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic [12:0] cmd_imm;
    logic        wr_valid, wr_ready, err_illegal;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  illegal_cnt;

    // Small-address instance
    logic        s_rst, s_cmd_valid, s_cmd_ready, s_cmd_use_imm;
    logic [3:0]  s_cmd_aluop;
    logic [4:0]  s_cmd_rd, s_cmd_rs1, s_cmd_rs2;
    logic [12:0] s_cmd_imm;
    logic        s_wr_valid, s_wr_ready, s_err_illegal;
    logic [1:0]  s_wr_addr;
    logic [31:0] s_wr_data;
    logic [7:0]  s_illegal_cnt;

    int tests = 0;
    int fails = 0;

    inst_encoder dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_aluop(cmd_aluop), .cmd_use_imm(cmd_use_imm), .cmd_rd(cmd_rd),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .err_illegal(err_illegal), .illegal_cnt(illegal_cnt)
    );

    inst_encoder #(.addr_width(2)) dut_small (
        .clk(clk), .rst(s_rst), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd_aluop(s_cmd_aluop), .cmd_use_imm(s_cmd_use_imm), .cmd_rd(s_cmd_rd),
        .cmd_rs1(s_cmd_rs1), .cmd_rs2(s_cmd_rs2), .cmd_imm(s_cmd_imm),
        .wr_valid(s_wr_valid), .wr_ready(s_wr_ready), .wr_addr(s_wr_addr),
        .wr_data(s_wr_data), .err_illegal(s_err_illegal), .illegal_cnt(s_illegal_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [3:0] op, input logic ui, input logic [4:0] rd,
                           input logic [4:0] r1, input logic [4:0] r2, input logic [12:0] im);
        cmd_valid = 1'b1; cmd_aluop = op; cmd_use_imm = ui;
        cmd_rd = rd; cmd_rs1 = r1; cmd_rs2 = r2; cmd_imm = im;
    endtask

    task automatic chk_word(input string tag, input logic [31:0] data, input logic [31:0] addr);
        chk({tag, "_valid"}, 32'(wr_valid), 32'd1);
        chk({tag, "_data"}, wr_data, data);
        chk({tag, "_addr"}, 32'(wr_addr), addr);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; wr_ready = 1'b0;
        set_cmd(4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 13'd0); cmd_valid = 1'b0;
        s_rst = 1'b1; s_cmd_valid = 1'b0; s_wr_ready = 1'b0; s_cmd_aluop = ALU_ADD;
        s_cmd_use_imm = 1'b0; s_cmd_rd = 5'd0; s_cmd_rs1 = 5'd0; s_cmd_rs2 = 5'd0; s_cmd_imm = 13'd0;
        step(); step();
        chk("rst_valid", 32'(wr_valid), 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_data", wr_data, 32'd0);
        chk("rst_err", 32'(err_illegal), 32'd0);
        chk("rst_cnt", 32'(illegal_cnt), 32'd0);
        rst = 1'b0; s_rst = 1'b0;
        #1 chk("rst_ready", 32'(cmd_ready), 32'd1);

        // Single R-type add, one-cycle latency, held while not ready
        set_cmd(ALU_ADD, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0);
        step(); cmd_valid = 1'b0;
        chk_word("add_r", 32'h002081B3, 32'd0);
        chk("add_r_ready", 32'(cmd_ready), 32'd0);
        step();
        chk_word("add_r_hold", 32'h002081B3, 32'd0);
        wr_ready = 1'b1;
        step();
        chk("add_r_drained", 32'(wr_valid), 32'd0);
        chk("add_r_next_addr", 32'(wr_addr), 32'd1);

        // Streaming with wr_ready high: accept and drain on the same edge
        set_cmd(ALU_ADD, 1'b1, 5'd1, 5'd0, 5'd0, 13'd5);       step(); chk_word("addi", 32'h00500093, 32'd1);
        set_cmd(ALU_SRA, 1'b1, 5'd5, 5'd6, 5'd0, 13'd3);       step(); chk_word("srai", 32'h40335293, 32'd2);
        set_cmd(ALU_EQ,  1'b0, 5'd0, 5'd1, 5'd2, 13'd8);       step(); chk_word("beq", 32'h00208463, 32'd3);
        set_cmd(ALU_SUB, 1'b0, 5'd1, 5'd2, 5'd3, 13'd0);       step(); chk_word("sub", 32'h403100B3, 32'd4);
        set_cmd(ALU_SLL, 1'b1, 5'd1, 5'd1, 5'd0, 13'h1FE3);    step(); chk_word("slli", 32'h00309093, 32'd5);
        set_cmd(ALU_NE,  1'b0, 5'd0, 5'd1, 5'd2, 13'h1FFC);    step(); chk_word("bne", 32'hFE209EE3, 32'd6);

        // Illegal subi accepted while the bne word drains
        set_cmd(ALU_SUB, 1'b1, 5'd1, 5'd2, 5'd0, 13'd1);
        step();
        chk("subi_valid", 32'(wr_valid), 32'd0);
        chk("subi_err", 32'(err_illegal), 32'd1);
        chk("subi_addr", 32'(wr_addr), 32'd7);
        chk("subi_cnt", 32'(illegal_cnt), 32'd1);
        cmd_valid = 1'b0;
        step();
        chk("subi_err_pulse", 32'(err_illegal), 32'd0);
        chk("subi_addr_kept", 32'(wr_addr), 32'd7);
        chk("subi_no_word", 32'(wr_valid), 32'd0);

        // Opcode 0 and an undefined opcode
        set_cmd(4'd0, 1'b0, 5'd1, 5'd1, 5'd1, 13'd0);  step();
        chk("op0_err", 32'(err_illegal), 32'd1);
        chk("op0_cnt", 32'(illegal_cnt), 32'd2);
        set_cmd(4'd15, 1'b0, 5'd1, 5'd1, 5'd1, 13'd0); step();
        chk("op15_cnt", 32'(illegal_cnt), 32'd3);
        chk("op15_valid", 32'(wr_valid), 32'd0);
        chk("op15_addr", 32'(wr_addr), 32'd7);
        cmd_valid = 1'b0;
        step();

        // Back-to-back commands with a three-cycle write stall
        wr_ready = 1'b0;
        set_cmd(ALU_ADD, 1'b0, 5'd10, 5'd11, 5'd12, 13'd0);
        step();
        chk_word("stall_first", 32'h00C58533, 32'd7);
        set_cmd(ALU_XOR, 1'b0, 5'd7, 5'd8, 5'd9, 13'd0);
        #1 chk("stall_ready", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_word("stall_hold", 32'h00C58533, 32'd7);
            chk("stall_ready_low", 32'(cmd_ready), 32'd0);
        end
        wr_ready = 1'b1;
        #1 chk("stall_ready_high", 32'(cmd_ready), 32'd1);
        step();
        chk_word("stall_second", 32'h009443B3, 32'd8);
        cmd_valid = 1'b0;
        step();
        chk("stall_done_valid", 32'(wr_valid), 32'd0);
        chk("stall_done_addr", 32'(wr_addr), 32'd9);

        // Illegal counter saturates at 255
        set_cmd(4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 13'd0);
        repeat (260) step();
        chk("cnt_sat", 32'(illegal_cnt), 32'd255);
        cmd_valid = 1'b0;
        step();
        chk("cnt_sat_err_clear", 32'(err_illegal), 32'd0);
        chk("cnt_sat_hold", 32'(illegal_cnt), 32'd255);

        // 2-bit address instance: wrap after four writes
        s_wr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_cmd_valid = 1'b1; s_cmd_rd = 5'(i);
            step();
            chk("wrap_addr", 32'(s_wr_addr), 32'(i % 4));
            chk("wrap_data", s_wr_data, (32'(i) << 7) | 32'h33);
        end
        s_cmd_valid = 1'b0;
        step();
        chk("wrap_drained_addr", 32'(s_wr_addr), 32'd1);

        // Reset while a word is stalled discards it
        s_wr_ready = 1'b0; s_cmd_valid = 1'b1; s_cmd_rd = 5'd9;
        step();
        s_cmd_valid = 1'b0;
        step();
        chk("hold_valid", 32'(s_wr_valid), 32'd1);
        chk("hold_addr", 32'(s_wr_addr), 32'd1);
        #2 s_rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(s_wr_valid), 32'd0);
        chk("midrst_addr", 32'(s_wr_addr), 32'd0);
        chk("midrst_data", s_wr_data, 32'd0);
        step();
        s_rst = 1'b0;
        step();
        chk("midrst_ready", 32'(s_cmd_ready), 32'd1);
        chk("midrst_idle", 32'(s_wr_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
